executor_movimento: RTL and testbench
=====================================

Name: executor_movimento

Overview:
Consumer end of the movement time-base. It takes the gated speed tick produced by the speed-selection logic (one-hot 2s/4s/8s select, enabled by LD) and runs one timed movement. Each tick advances a 4-phase leg pattern and decrements a remaining-tick count. The count is shown on a 7-segment digit, and the block reports busy/done/error to the top-level controller.

Parameters:
MOV_TICKS, 8, ticks per movement (legal 1..9; the displayed digit is the remaining-tick count)

Ports:
clk      in   1  system clock
rst_n    in   1  synchronous active-low reset
tempo    in   1  gated time-base square wave, generated in the clk domain; one rising edge = one tick
sel      in   3  speed select {T8s,T4s,T2s}; exactly one bit must be set
ld       in   1  movement enable (LD); low = pause
start    in   1  request to begin a movement, level-sampled
abort    in   1  cancel the current movement or clear an error
leg      out  4  one-hot leg phase (0001 -> 0010 -> 0100 -> 1000 -> 0001)
busy     out  1  high in RUN and PAUSE
done     out  1  one-cycle pulse when a movement completes
erro     out  1  high in ERROR
seg      out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state and all outputs are registered.
- Reset values: state=IDLE, rem=0, leg=0000, busy=0, done=0, erro=0, seg=8'hFF (blank), tempo_q=0, sel_lat=000.
- Tick detection: tick = tempo & ~tempo_q, with tempo_q the registered tempo. A tempo high lasting N cycles produces one tick.
- sel_ok = exactly one bit of sel set. 000, 011, 101, 110 and 111 are invalid.
- Outputs are Moore: they are visible in the cycle after the edge that changes state or rem.
- IDLE:
  - start & ~sel_ok -> ERROR.
  - start & sel_ok & ld -> RUN; rem=MOV_TICKS, leg=0001, sel_lat=sel.
  - start & sel_ok & ~ld -> stay IDLE (request ignored; start must be re-asserted).
  - Ticks are ignored.
- RUN, priority highest first:
  1. abort -> IDLE.
  2. sel != sel_lat -> ERROR.
  3. ~ld -> PAUSE.
  4. tick:
     - if rem==1 -> DONE.
     - otherwise rem=rem-1 and leg rotates left one position.
  - start is ignored in RUN.
- PAUSE:
  - abort -> IDLE.
  - sel != sel_lat -> ERROR.
  - ld -> RUN.
  - Ticks in PAUSE are discarded, including a tick in the same cycle ld returns. rem and leg are held.
- DONE: lasts one cycle. done=1, rem=0, leg=0000. Unconditional next state IDLE. abort in this cycle is irrelevant.
- ERROR: erro=1, leg=0000, busy=0. Exits only on abort (-> IDLE) or rst_n=0. start is ignored.
- seg by state:
  - IDLE: blank (FF).
  - RUN: digit rem, dp off.
  - PAUSE: digit rem, dp on (bit7=0).
  - DONE: digit 0 (C0).
  - ERROR: 'E' (86).
- rem is 4 bits wide and never wraps; a decrement from 1 goes to DONE, not to 0-in-RUN.
- Reset mid-operation: rst_n low in any state forces the reset values on the next edge. No done pulse is generated.
- Latency:
  - First tick after start: counted if its rising edge is sampled at least one edge after the RUN entry edge.
  - Last tick to done: done is asserted the cycle after the edge on which rem==1 sees the tick.

Decomposition:
- Package mov_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE, ERROR};
  - one-hot SEL_2S=3'b001, SEL_4S=3'b010, SEL_8S=3'b100;
  - 7-segment constants SEG_BLANK=8'hFF, SEG_E=8'h86, and the active-low digit table 0..9.
- One sub-module, decodificador_7seg: a combinational digit-to-segment lookup using the package table; dp is handled in the parent.
- The FSM, counter, tick detector and leg rotator stay in executor_movimento.

Test Plan (MOV_TICKS=4):
1. Normal run: sel=001, ld=1, start pulse, then 4 tempo rising edges.
   - seg goes 99 -> B0 -> A4 -> F9 (4,3,2,1) while leg steps 0001 -> 0010 -> 0100 -> 1000.
   - After the 4th edge: done=1 for exactly 1 cycle, leg=0000, seg=C0, then seg=FF with busy=0.
2. Pause: in RUN after 1 tick (rem=3), drop ld and apply 2 tempo edges, then raise ld.
   - While ld is low: seg=30 (3 with dp on) and leg=0010 is held.
   - After ld returns: rem stays 3 and exactly 3 further ticks complete the move.
3. Invalid selection: start with sel=011 -> erro=1, seg=86, busy=0.
   - start again -> no change.
   - abort -> IDLE, seg=FF, erro=0.
4. Selection change mid-run: in RUN with sel_lat=010, set sel=100 -> ERROR next edge, leg=0000, no done pulse.
5. Priority: in RUN, assert abort, ~ld and a tick in the same cycle -> IDLE; rem is not decremented; done stays 0.
6. Reset mid-run: rst_n=0 for 1 cycle at rem=2 -> all outputs at their reset values, seg=FF. A following tempo edge causes no change until a new start.

Source files
------------

// File: rtl/mov_pkg.sv
// Shared types and constants for the movement executor: FSM states, speed
// selects and the active-low 7-segment table ({dp,g,f,e,d,c,b,a}).
package mov_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_e;

   localparam logic [2:0] SEL_2S = 3'b001;
   localparam logic [2:0] SEL_4S = 3'b010;
   localparam logic [2:0] SEL_8S = 3'b100;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_E     = 8'h86;

   // Digits 0..9 with dp off
   localparam logic [7:0] SEG_DIGITS [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational digit-to-segment lookup {g..a}, active-low; the parent owns dp.
module decodificador_7seg
   import mov_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK[6:0];
      if (digit <= 4'd9) begin
         seg = SEG_DIGITS[digit][6:0];
      end
   end

endmodule

// File: rtl/executor_movimento.sv
// Runs one timed movement: counts gated speed ticks, rotates the leg phase and
// drives a remaining-tick digit plus busy/done/erro status, all registered.
module executor_movimento
   import mov_pkg::*;
#(
   parameter int unsigned MOV_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tempo,
   input  logic [2:0] sel,
   input  logic       ld,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] leg,
   output logic       busy,
   output logic       done,
   output logic       erro,
   output logic [7:0] seg
);

   localparam logic [3:0] MOV_REM = 4'(MOV_TICKS);

   state_e     state_q, state_d;
   logic [3:0] rem_q, rem_d;
   logic [3:0] leg_d;
   logic [2:0] sel_lat_q, sel_lat_d;
   logic       tempo_q;
   logic       busy_d, done_d, erro_d;
   logic [7:0] seg_d;
   logic [6:0] dig_seg;
   logic       tick, sel_ok;

   assign tick   = tempo & ~tempo_q;
   assign sel_ok = (sel == SEL_2S) || (sel == SEL_4S) || (sel == SEL_8S);

   decodificador_7seg u_dec (
      .digit(rem_d),
      .seg  (dig_seg)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      leg_d     = leg;
      sel_lat_d = sel_lat_q;
      unique case (state_q)
         IDLE: begin
            if (start && !sel_ok) begin
               state_d = ERROR;
               leg_d   = 4'b0000;
            end else if (start && ld) begin
               state_d   = RUN;
               rem_d     = MOV_REM;
               leg_d     = 4'b0001;
               sel_lat_d = sel;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               leg_d   = 4'b0000;
            end else if (sel != sel_lat_q) begin
               state_d = ERROR;
               leg_d   = 4'b0000;
            end else if (!ld) begin
               state_d = PAUSE;
            end else if (tick) begin
               if (rem_q == 4'd1) begin
                  state_d = DONE;
                  rem_d   = 4'd0;
                  leg_d   = 4'b0000;
               end else begin
                  rem_d = rem_q - 4'd1;
                  leg_d = {leg[2:0], leg[3]};
               end
            end
         end
         PAUSE: begin
            // A tick coinciding with ld returning is deliberately dropped
            if (abort) begin
               state_d = IDLE;
               leg_d   = 4'b0000;
            end else if (sel != sel_lat_q) begin
               state_d = ERROR;
               leg_d   = 4'b0000;
            end else if (ld) begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERROR: begin
            if (abort) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            leg_d   = 4'b0000;
         end
      endcase
   end

   // Outputs are computed from next state so the registered copies are Moore
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      erro_d = 1'b0;
      seg_d  = SEG_BLANK;
      unique case (state_d)
         IDLE:  seg_d = SEG_BLANK;
         RUN: begin
            busy_d = 1'b1;
            seg_d  = {1'b1, dig_seg};
         end
         PAUSE: begin
            busy_d = 1'b1;
            seg_d  = {1'b0, dig_seg};
         end
         DONE: begin
            done_d = 1'b1;
            seg_d  = SEG_DIGITS[0];
         end
         ERROR: begin
            erro_d = 1'b1;
            seg_d  = SEG_E;
         end
         default: seg_d = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rem_q     <= 4'd0;
         leg       <= 4'b0000;
         sel_lat_q <= 3'b000;
         tempo_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         erro      <= 1'b0;
         seg       <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         leg       <= leg_d;
         sel_lat_q <= sel_lat_d;
         tempo_q   <= tempo;
         busy      <= busy_d;
         done      <= done_d;
         erro      <= erro_d;
         seg       <= seg_d;
      end
   end

endmodule

// File: tb/tb_executor_movimento.sv
// Directed bench for executor_movimento with MOV_TICKS=4; outputs are checked
// 1 time unit after each rising clock edge against hand-computed values.
module tb_executor_movimento;

   logic       clk;
   logic       rst_n;
   logic       tempo;
   logic [2:0] sel;
   logic       ld;
   logic       start;
   logic       abort;
   logic [3:0] leg;
   logic       busy;
   logic       done;
   logic       erro;
   logic [7:0] seg;

   int n_cmp = 0;
   int n_err = 0;

   executor_movimento #(
      .MOV_TICKS(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tempo(tempo),
      .sel  (sel),
      .ld   (ld),
      .start(start),
      .abort(abort),
      .leg  (leg),
      .busy (busy),
      .done (done),
      .erro (erro),
      .seg  (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e_seg, input logic [3:0] e_leg,
                          input logic e_busy, input logic e_done, input logic e_erro);
      chk({tag, ".seg"}, seg, e_seg);
      chk({tag, ".leg"}, 8'(leg), 8'(e_leg));
      chk({tag, ".busy"}, 8'(busy), 8'(e_busy));
      chk({tag, ".done"}, 8'(done), 8'(e_done));
      chk({tag, ".erro"}, 8'(erro), 8'(e_erro));
   endtask

   initial begin
      rst_n = 1'b0;
      tempo = 1'b0;
      sel   = 3'b001;
      ld    = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_all("reset", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);

      // 1: normal run
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("t1.start", 8'h99, 4'b0001, 1'b1, 1'b0, 1'b0);
      tempo = 1'b1; step(); chk_all("t1.tick1", 8'hB0, 4'b0010, 1'b1, 1'b0, 1'b0);
      tempo = 1'b0; step(); chk("t1.hold", seg, 8'hB0);
      tempo = 1'b1; step(); chk_all("t1.tick2", 8'hA4, 4'b0100, 1'b1, 1'b0, 1'b0);
      tempo = 1'b0; step();
      tempo = 1'b1; step(); chk_all("t1.tick3", 8'hF9, 4'b1000, 1'b1, 1'b0, 1'b0);
      tempo = 1'b0; step();
      tempo = 1'b1; step(); chk_all("t1.done", 8'hC0, 4'b0000, 1'b0, 1'b1, 1'b0);
      tempo = 1'b0; step(); chk_all("t1.idle", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);

      // 2: pause holds rem and leg, ticks discarded
      start = 1'b1; step(); start = 1'b0;
      tempo = 1'b1; step(); chk_all("t2.tick1", 8'hB0, 4'b0010, 1'b1, 1'b0, 1'b0);
      tempo = 1'b0; ld = 1'b0; step(); chk_all("t2.pause", 8'h30, 4'b0010, 1'b1, 1'b0, 1'b0);
      tempo = 1'b1; step(); tempo = 1'b0; step();
      tempo = 1'b1; step(); chk_all("t2.ptick", 8'h30, 4'b0010, 1'b1, 1'b0, 1'b0);
      tempo = 1'b0; step();
      ld = 1'b1; step(); chk_all("t2.resume", 8'hB0, 4'b0010, 1'b1, 1'b0, 1'b0);
      tempo = 1'b1; step(); chk("t2.tick2", seg, 8'hA4);
      tempo = 1'b0; step();
      tempo = 1'b1; step(); chk("t2.tick3", seg, 8'hF9);
      tempo = 1'b0; step();
      tempo = 1'b1; step(); chk("t2.done", 8'(done), 8'h01);
      tempo = 1'b0; step(); chk("t2.idle", 8'(busy), 8'h00);

      // 3: invalid select
      sel = 3'b011; start = 1'b1; step();
      chk_all("t3.err", 8'h86, 4'b0000, 1'b0, 1'b0, 1'b1);
      step(); chk_all("t3.again", 8'h86, 4'b0000, 1'b0, 1'b0, 1'b1);
      start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
      chk_all("t3.abort", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);

      // 4: select change mid-run
      sel = 3'b010; start = 1'b1; step(); start = 1'b0;
      chk("t4.run", seg, 8'h99);
      sel = 3'b100; step();
      chk_all("t4.err", 8'h86, 4'b0000, 1'b0, 1'b0, 1'b1);
      abort = 1'b1; step(); abort = 1'b0; sel = 3'b001;
      chk("t4.abort", 8'(erro), 8'h00);

      // 5: abort beats ~ld and tick
      start = 1'b1; step(); start = 1'b0;
      chk("t5.run", seg, 8'h99);
      tempo = 1'b1; abort = 1'b1; ld = 1'b0; step();
      chk_all("t5.abort", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);
      tempo = 1'b0; abort = 1'b0; ld = 1'b1; step();
      chk("t5.nodone", 8'(done), 8'h00);

      // 6: reset mid-run at rem=2
      start = 1'b1; step(); start = 1'b0;
      tempo = 1'b1; step(); tempo = 1'b0; step();
      tempo = 1'b1; step(); tempo = 1'b0;
      chk("t6.rem2", seg, 8'hA4);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk_all("t6.reset", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);
      step();
      tempo = 1'b1; step(); tempo = 1'b0; step();
      chk_all("t6.tick", 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
